// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, states, mux selects.
// Build option CTRL_JAL_EN enables the JAL opcode.
package control_pkg;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_R_WB,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] RDST_RT   = 2'b00;
  localparam logic [1:0] RDST_RD   = 2'b01;
  localparam logic [1:0] RDST_LINK = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       jump;
    logic       jump_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/control_word_decode.sv
// Combinational map from (state, opcode, mem_ready) to the datapath control word.
// Link writeback in JUMP exists only with CTRL_JAL_EN.
module control_word_decode
  import control_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_b = SRCB_TWO;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = PCS_ALU;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RDST_RD;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RDST_RT;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.jump      = 1'b1;
        ctrl.jump_cond = (opcode == OP_BEQ);
        ctrl.pc_source = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
`ifdef CTRL_JAL_EN
        // Link is the PC already advanced in FETCH.
        if (opcode == OP_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = RDST_LINK;
          ctrl.mem_to_reg = M2R_PC;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: state register, next-state logic, sticky halt flags.
// Define CTRL_JAL_EN to accept opcode 7 as JAL; otherwise it is illegal.
module multicycle_control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       jump,
  output logic       jump_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_R:    state_d = S_EXEC_R;
          OP_ADDI: state_d = S_EXEC_I;
          OP_LW:   state_d = S_MEM_ADDR;
          OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:  state_d = S_BRANCH;
          OP_BNE:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
`ifdef CTRL_JAL_EN
          OP_JAL:  state_d = S_JUMP;
`endif
          OP_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: begin
        state_d = (opcode == OP_LW) ? S_MEM_READ
                                    : S_MEM_WRITE;
      end
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_WB, S_I_WB, S_MEM_WB,
      S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  control_word_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign jump       = ctrl.jump;
  assign jump_cond  = ctrl.jump_cond;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level schedule model plus directed pins.
// Honours CTRL_JAL_EN the same way as the design build.
module tb_multicycle_control_fsm;

`ifdef CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       pc_write, jump, jump_cond, ir_write;
  logic       mem_read, mem_write, iord, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       alu_src_a, halted, illegal;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready), .pc_write(pc_write),
    .jump(jump), .jump_cond(jump_cond),
    .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .halted(halted),
    .illegal(illegal)
  );

  typedef struct packed {
    logic       pc_write;
    logic       jump;
    logic       jump_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal;
  } exp_t;

  // One cycle of an instruction's schedule; waiting steps repeat while mem_ready is low.
  typedef struct packed {
    exp_t wo;
    exp_t go;
    logic waits;
    logic fetch;
    logic halt;
    logic ill;
  } step_t;

  exp_t  act, last, expv;
  step_t q[$];
  bit    halted_m, illegal_m, armed;
  logic [3:0] cur_op = 4'h0;
  int    force_op = -1;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ncyc = 0;

  assign act = {pc_write, jump, jump_cond, ir_write,
                mem_read, mem_write, iord, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_op, pc_source, halted, illegal};

  function automatic step_t st(input exp_t g);
    step_t s;
    s = '0;
    s.wo = g;
    s.go = g;
    return s;
  endfunction

  task automatic push_fetch();
    step_t s;
    s = '0;
    s.wo.mem_read  = 1'b1;
    s.go.mem_read  = 1'b1;
    s.go.ir_write  = 1'b1;
    s.go.pc_write  = 1'b1;
    s.go.alu_src_b = 2'b01;
    s.waits = 1'b1;
    s.fetch = 1'b1;
    q.push_back(s);
  endtask

  task automatic push_mem(input bit wr);
    step_t s;
    s = '0;
    s.wo.iord = 1'b1;
    if (wr) s.wo.mem_write = 1'b1;
    else    s.wo.mem_read  = 1'b1;
    s.go = s.wo;
    s.waits = 1'b1;
    q.push_back(s);
  endtask

  // Cycles following a completed fetch, written from the instruction's meaning.
  task automatic push_body(input logic [3:0] op);
    exp_t e;
    step_t dec;
    e = '0;
    e.alu_src_b = 2'b11;
    dec = st(e);
    if (op == 4'hF || op > 4'h7 || (op == 4'h7 && !JAL_EN)) begin
      dec.halt = 1'b1;
      dec.ill  = (op != 4'hF);
      q.push_back(dec);
      return;
    end
    q.push_back(dec);
    e = '0;
    case (op)
      4'h0: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        q.push_back(st(e));
        e = '0; e.reg_write = 1'b1; e.reg_dst = 2'b01;
        q.push_back(st(e));
      end
      4'h1: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        q.push_back(st(e));
        e = '0; e.reg_write = 1'b1;
        q.push_back(st(e));
      end
      4'h2, 4'h3: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        q.push_back(st(e));
        push_mem(op == 4'h3);
        if (op == 4'h2) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
          q.push_back(st(e));
        end
      end
      4'h4, 4'h5: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b01;
        e.jump = 1'b1; e.jump_cond = (op == 4'h4);
        e.pc_source = 2'b01;
        q.push_back(st(e));
      end
      default: begin
        e.pc_write = 1'b1; e.pc_source = 2'b10;
        if (op == 4'h7) begin
          e.reg_write = 1'b1; e.reg_dst = 2'b10;
          e.mem_to_reg = 2'b10;
        end
        q.push_back(st(e));
      end
    endcase
  endtask

  function automatic logic [3:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 85) return 4'($urandom_range(0, 7));
    if (r < 92) return 4'hF;
    return 4'($urandom_range(8, 14));
  endfunction

  function automatic exp_t expected(input bit rdy);
    exp_t e;
    e = '0;
    if (halted_m) begin
      e.halted  = 1'b1;
      e.illegal = illegal_m;
    end else if (q[0].waits && !rdy) begin
      e = q[0].wo;
    end else begin
      e = q[0].go;
    end
    return e;
  endfunction

  task automatic advance(input bit r, input bit rdy);
    step_t s;
    if (r) begin
      q.delete();
      halted_m  = 1'b0;
      illegal_m = 1'b0;
      q.push_back(st('0));
      push_fetch();
      armed = 1'b1;
      return;
    end
    if (!armed || halted_m) return;
    s = q[0];
    if (s.waits && !rdy) return;
    void'(q.pop_front());
    if (s.fetch) begin
      cur_op = (force_op >= 0) ? force_op[3:0] : pick();
      push_body(cur_op);
    end
    if (s.halt) begin
      halted_m  = 1'b1;
      illegal_m = s.ill;
    end
    if (q.size() == 0 && !halted_m) push_fetch();
  endtask

  task automatic cyc(input bit r, input bit rdy);
    @(negedge clk);
    reset     = r;
    mem_ready = rdy;
    opcode    = cur_op;
    #1;
    last = act;
    ncyc++;
    if (armed) begin
      expv = expected(rdy);
      n_cmp++;
      if (act !== expv) begin
        n_bad++;
        $display("FAIL model cyc=%0d op=%h act=%h exp=%h",
                 ncyc, cur_op, act, expv);
      end
    end
    advance(r, rdy);
  endtask

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  int nw;

  initial begin
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    lit("rst_zero", 32'(last), 32'h0);

    force_op = 0;
    cyc(1'b0, 1'b1);
    lit("r_fetch_irw", 32'(last.ir_write), 32'h1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    lit("r_exec_regw", 32'(last.reg_write), 32'h0);
    cyc(1'b0, 1'b1);
    lit("r_wb_regw", 32'(last.reg_write), 32'h1);
    lit("r_wb_dst", 32'(last.reg_dst), 32'h1);

    force_op = 2;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    nw = 0;
    cyc(1'b0, 1'b0); nw += int'(last.mem_read & last.iord);
    cyc(1'b0, 1'b0); nw += int'(last.mem_read & last.iord);
    cyc(1'b0, 1'b1); nw += int'(last.mem_read & last.iord);
    lit("lw_wait_cycles", 32'(nw), 32'd3);
    cyc(1'b0, 1'b1);
    lit("lw_wb_m2r", 32'(last.mem_to_reg), 32'h1);
    lit("lw_wb_regw", 32'(last.reg_write), 32'h1);

    force_op = 4;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    lit("beq_br", {last.jump, last.jump_cond, last.pc_write}, 32'b110);
    force_op = 5;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    lit("bne_br", {last.jump, last.jump_cond, last.pc_write}, 32'b100);

    force_op = 7;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    if (JAL_EN) begin
      lit("jal_jump", {last.pc_write, last.pc_source, last.reg_write,
          last.reg_dst, last.mem_to_reg}, 32'b1_10_1_10_10);
    end else begin
      lit("jal_illegal", {last.halted, last.illegal}, 32'b11);
    end

    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    force_op = 9;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)));
      lit("ill_park", 32'(last), 32'h3);
    end

    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    force_op = 3;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    lit("sw_wait_mw", 32'(last.mem_write), 32'h1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    lit("sw_rst_zero", 32'(last), 32'h0);
    cyc(1'b0, 1'b1);
    lit("sw_rst_fetch", 32'(last.mem_read), 32'h1);

    force_op = -1;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      r = ($urandom_range(0, 199) == 0) ||
          (halted_m && $urandom_range(0, 7) == 0);
      cyc(r, ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the 16-bit multicycle processor. Decodes the 4-bit opcode held in the instruction register and steps the shared datapath through fetch, decode, execute, memory and writeback. It drives every datapath control line, including the `pc_write`, `jump` and `jump_cond` inputs of the PC-enable logic. It also stalls on a memory ready handshake and parks the processor on HALT or on an illegal opcode.

## Interface
- No parameters; widths are fixed by the ISA.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 4: IR[15:12]; stable from DECODE until the next FETCH completes.
- `mem_ready` input 1: memory completes the current `mem_read`/`mem_write` this cycle.
- `pc_write` output 1: unconditional PC write.
- `jump` output 1: conditional branch enable.
- `jump_cond` output 1: branch taken when it equals the zero flag (1 = BEQ, 0 = BNE).
- `ir_write` output 1: latch fetched word into IR.
- `mem_read`, `mem_write` output 1 each: memory request strobes.
- `iord` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `reg_write` output 1: register file write enable.
- `reg_dst` output 2: write register select, 00 = rt, 01 = rd, 10 = r7 (link).
- `mem_to_reg` output 2: writeback data select, 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a` output 1: ALU A select, 0 = PC, 1 = A register.
- `alu_src_b` output 2: ALU B select, 00 = B register, 01 = constant 2, 10 = sign-extended immediate, 11 = sign-extended immediate << 1.
- `alu_op` output 2: 00 = add, 01 = sub, 10 = use function field.
- `pc_source` output 2: PC data select, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `halted` output 1: sticky halt indication.
- `illegal` output 1: sticky, set when the halt was caused by an illegal opcode.

## Operation
- Opcodes: 0 = R-type, 1 = ADDI, 2 = LW, 3 = SW, 4 = BEQ, 5 = BNE, 6 = J, 7 = JAL, F = HALT; 8–E are illegal.
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, R_WB, I_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, HALT.
- Any output not listed for a state is 0.
- RST: all outputs 0. Always moves to FETCH.
- FETCH: `mem_read`=1, `iord`=0.
  - While `mem_ready`=0: stay in FETCH; `ir_write`=0, `pc_write`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `alu_src_b`=01, `alu_op`=00, `pc_source`=00 (PC+2); go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - 0 → EXEC_R; 1 → EXEC_I; 2, 3 → MEM_ADDR; 4, 5 → BRANCH; 6, 7 → JUMP; F → HALT.
  - Illegal opcode → HALT and set `illegal`.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00 → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → I_WB.
- I_WB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00 → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read`=1, `iord`=1; holds until `mem_ready`, then → MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01 → FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1; holds until `mem_ready`, then → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `jump`=1, `jump_cond`=(opcode==4), `pc_source`=01 → FETCH.
- JUMP: `pc_write`=1, `pc_source`=10.
  - JAL additionally: `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10.
  - The link value is the already-incremented PC, written in the same cycle as the PC update.
  - → FETCH.
- HALT: all control outputs 0, `halted`=1. Terminal until `reset`.

## Timing
- Moore outputs, decoded from the state register, except the FETCH `ir_write`/`pc_write` qualification by `mem_ready`.
- The state register updates on the rising edge of `clk`.
- Cycle counts with zero wait states: R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J/JAL 3.
- Each wait cycle (`mem_ready`=0) adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- `mem_ready` outside those three states is ignored.
- Reset outputs: state RST, every output 0, `halted`=0, `illegal`=0.
- `reset` asserted in any state, including mid-wait or HALT, takes priority: next state RST, and `halted`/`illegal` clear on the same edge.
- An in-flight memory request is abandoned by reset; the memory side must tolerate a dropped strobe.

## Configuration
- `CTRL_JAL_EN` defined: opcode 7 is JAL as described above.
- `CTRL_JAL_EN` undefined:
  - Opcode 7 is illegal (DECODE → HALT, `illegal`=1).
  - `reg_dst`=10 and `mem_to_reg`=10 are never driven.

## Structure
- Shared package `control_pkg` holds:
  - opcode constants;
  - the state enum;
  - the `alu_op`, `alu_src_b`, `pc_source`, `reg_dst` and `mem_to_reg` encodings.
- Natural sub-module: `control_word_decode`, a combinational map from (state, opcode, `mem_ready`) to the output control word.
- The top level holds only the state register, next-state logic and the sticky `halted`/`illegal` flags.

## Test plan
- Reset, then opcode 0 with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, R_WB, FETCH; `reg_write`=1 with `reg_dst`=01 on the 4th cycle only.
- LW with `mem_ready` low for 2 cycles in MEM_READ → `mem_read`=1 and `iord`=1 held 3 cycles, 7 cycles total, then MEM_WB with `mem_to_reg`=01.
- BEQ then BNE → in BRANCH, `jump`=1 with `jump_cond`=1, then `jump`=1 with `jump_cond`=0; `pc_write`=0 in both.
- JAL with `CTRL_JAL_EN` defined → JUMP: `pc_write`=1, `pc_source`=10, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. Without the macro → `halted`=1, `illegal`=1.
- Opcode 9 → HALT after DECODE, `illegal`=1; outputs stay 0 for 10 cycles regardless of `mem_ready`.
- `reset` asserted during a MEM_WRITE wait → next cycle RST with all outputs 0, then FETCH.
